// File: rtl/mem_wb_stage.sv
// mem_wb_stage: the MEM pipeline stage and the MEM/WB register behind it.
// A load or store runs a single req/ack handshake with the data memory. The
// stage stalls the pipeline until the ack arrives or the wait limit expires.
// Every other instruction passes through to MEM/WB with one cycle of latency.
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX/MEM register
    input  logic [31:2] Branch_dst,
    input  logic        Zero,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  Write_Destination,
    input  logic [1:0]  WB,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    // data memory
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:2] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    // fetch / hazard
    output logic        PCSrc,
    output logic [31:2] Branch_target,
    output logic        stall,
    output logic        mem_err,
    // MEM/WB register
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [31:0] ReadData,
    output logic [31:0] ALU_result_wb,
    output logic [4:0]  Write_Destination_wb
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Instruction parked while its memory access is outstanding.
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        load;
        logic [31:0] alu;
        logic [4:0]  dest;
    } pend_t;

    // MEM/WB register contents.
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu;
        logic [4:0]  dest;
    } memwb_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  wait_cnt, cnt_nx;
    logic        req_nx, we_nx, err_nx;
    logic [31:2] addr_nx;
    logic [31:0] wdata_nx;
    pend_t       pend, pend_nx;
    memwb_t      wb_q, wb_nx;

    logic mem_op, misaligned, valid_op, both_op, timeout_hit;

    assign mem_op      = MemRead | MemWrite;
    assign misaligned  = mem_op & (ALU_result[1:0] != 2'b00);
    assign valid_op    = mem_op & ~misaligned;
    // A store wins when both strobes are set, so nothing is loaded to the register file.
    assign both_op     = MemRead & MemWrite;
    assign timeout_hit = (state == ACCESS) & (wait_cnt == WAIT_LAST) & ~dmem_ack;

    assign stall = ((state == IDLE) & valid_op)
                 | ((state == ACCESS) & ~dmem_ack & ~timeout_hit);

    assign PCSrc         = Branch & Zero & ~stall;
    assign Branch_target = Branch_dst;

    assign RegWrite             = wb_q.reg_write;
    assign MemtoReg             = wb_q.mem_to_reg;
    assign ReadData             = wb_q.read_data;
    assign ALU_result_wb        = wb_q.alu;
    assign Write_Destination_wb = wb_q.dest;

    // Next-state and next-register values. A stalled or aborted cycle writes a
    // bubble: only the two control bits are cleared, and the data fields are kept.
    always_comb begin
        state_nx = state;
        req_nx   = dmem_req;
        we_nx    = dmem_we;
        addr_nx  = dmem_addr;
        wdata_nx = dmem_wdata;
        cnt_nx   = wait_cnt;
        err_nx   = mem_err;
        pend_nx  = pend;
        wb_nx    = wb_q;
        unique case (state)
            IDLE: begin
                // An ack seen while IDLE does not belong to any request, so it is ignored.
                if (valid_op) begin
                    state_nx           = ACCESS;
                    req_nx             = 1'b1;
                    we_nx              = MemWrite;
                    addr_nx            = ALU_result[31:2];
                    wdata_nx           = ReadData2;
                    cnt_nx             = 8'd0;
                    pend_nx.reg_write  = WB[0];
                    pend_nx.mem_to_reg = WB[1] & ~both_op;
                    pend_nx.load       = MemRead & ~MemWrite;
                    pend_nx.alu        = ALU_result;
                    pend_nx.dest       = Write_Destination;
                    wb_nx.reg_write    = 1'b0;
                    wb_nx.mem_to_reg   = 1'b0;
                end else if (misaligned) begin
                    err_nx           = 1'b1;
                    wb_nx.reg_write  = 1'b0;
                    wb_nx.mem_to_reg = 1'b0;
                end else begin
                    wb_nx.reg_write  = WB[0];
                    wb_nx.mem_to_reg = WB[1];
                    wb_nx.alu        = ALU_result;
                    wb_nx.dest       = Write_Destination;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_nx         = IDLE;
                    req_nx           = 1'b0;
                    wb_nx.reg_write  = pend.reg_write;
                    wb_nx.mem_to_reg = pend.mem_to_reg;
                    wb_nx.alu        = pend.alu;
                    wb_nx.dest       = pend.dest;
                    if (pend.load)
                        wb_nx.read_data = dmem_rdata;
                end else if (timeout_hit) begin
                    state_nx         = IDLE;
                    req_nx           = 1'b0;
                    err_nx           = 1'b1;
                    wb_nx.reg_write  = 1'b0;
                    wb_nx.mem_to_reg = 1'b0;
                end else begin
                    cnt_nx           = wait_cnt + 8'd1;
                    wb_nx.reg_write  = 1'b0;
                    wb_nx.mem_to_reg = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register; an asynchronous reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Memory request, wait counter, error flag, parked instruction and MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wait_cnt   <= 8'd0;
            mem_err    <= 1'b0;
            pend       <= '0;
            wb_q       <= '0;
        end else begin
            dmem_req   <= req_nx;
            dmem_we    <= we_nx;
            dmem_addr  <= addr_nx;
            dmem_wdata <= wdata_nx;
            wait_cnt   <= cnt_nx;
            mem_err    <= err_nx;
            pend       <= pend_nx;
            wb_q       <= wb_nx;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage with a per-instruction reference model.
// The model works one instruction at a time. It takes the instruction kind and
// the ack latency chosen for it. From these it predicts the stall pattern, the
// request fields and the MEM/WB contents after every edge.
module tb_mem_wb_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:2] Branch_dst;
    logic        Zero;
    logic [31:0] ALU_result;
    logic [31:0] ReadData2;
    logic [4:0]  Write_Destination;
    logic [1:0]  WB;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:2] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        PCSrc;
    logic [31:2] Branch_target;
    logic        stall;
    logic        mem_err;
    logic        RegWrite;
    logic        MemtoReg;
    logic [31:0] ReadData;
    logic [31:0] ALU_result_wb;
    logic [4:0]  Write_Destination_wb;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .Branch_dst(Branch_dst), .Zero(Zero), .ALU_result(ALU_result),
        .ReadData2(ReadData2), .Write_Destination(Write_Destination), .WB(WB),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .PCSrc(PCSrc), .Branch_target(Branch_target), .stall(stall), .mem_err(mem_err),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData),
        .ALU_result_wb(ALU_result_wb), .Write_Destination_wb(Write_Destination_wb)
    );

    int checks = 0;
    int errors = 0;

    // reference model of the MEM/WB register and the sticky error flag
    logic        m_rw, m_m2r, m_err;
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_wd;
    // request fields expected while a request is outstanding
    logic [31:2] x_addr;
    logic        x_we;
    logic [31:0] x_wdata;
    // last request fields observed on the bus, used for the literal checks
    logic [31:2] last_addr;
    logic        last_we;
    logic [31:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        chk("RegWrite", 32'(RegWrite), 32'(m_rw));
        chk("MemtoReg", 32'(MemtoReg), 32'(m_m2r));
        chk("ReadData", ReadData, m_rd);
        chk("ALU_result_wb", ALU_result_wb, m_alu);
        chk("Write_Destination_wb", 32'(Write_Destination_wb), 32'(m_wd));
        chk("mem_err", 32'(mem_err), 32'(m_err));
    endtask

    task automatic model_reset();
        m_rw = 1'b0; m_m2r = 1'b0; m_err = 1'b0;
        m_rd = '0; m_alu = '0; m_wd = '0;
    endtask

    task automatic clear_inputs();
        Branch_dst = '0; Zero = 1'b0; ALU_result = '0; ReadData2 = '0;
        Write_Destination = '0; WB = 2'b00; Branch = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    endtask

    // Check one cycle at the falling edge, then advance to just past the next rising edge.
    task automatic step(input logic e_stall, input logic e_req);
        @(negedge clk);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("PCSrc", 32'(PCSrc), 32'(Branch & Zero & ~e_stall));
        chk("Branch_target", 32'(Branch_target), 32'(Branch_dst));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        if (e_req) begin
            chk("dmem_addr", 32'(dmem_addr), 32'(x_addr));
            chk("dmem_we", 32'(dmem_we), 32'(x_we));
            chk("dmem_wdata", dmem_wdata, x_wdata);
            last_addr = dmem_addr; last_we = dmem_we; last_wdata = dmem_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset dmem_req", 32'(dmem_req), 32'd0);
        chk("reset dmem_addr", 32'(dmem_addr), 32'd0);
        chk("reset dmem_wdata", dmem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    // Issue one instruction. lat is the number of access cycles without an ack
    // before the ack arrives; lat >= TO means no ack comes, so the access times out.
    task automatic run_instr(input logic rd, input logic wr, input logic [31:0] alu,
                             input logic [31:0] wdata, input logic [1:0] wb, input logic [4:0] wd,
                             input int lat, input logic br, input logic zr, input logic [31:2] bdst,
                             input logic fix, input logic [31:0] fixv, output int nstall);
        logic mem, mis;
        logic [31:0] captured;
        int waits;
        MemRead = rd; MemWrite = wr; ALU_result = alu; ReadData2 = wdata;
        WB = wb; Write_Destination = wd; Branch = br; Zero = zr; Branch_dst = bdst;
        dmem_rdata = $urandom;
        dmem_ack = 1'($urandom);   // an ack in IDLE has to be ignored
        mem = rd | wr;
        mis = mem && (alu[1:0] != 2'b00);
        nstall = 0;
        if (!mem || mis) begin
            step(1'b0, 1'b0);
            if (mis) begin
                m_rw = 1'b0; m_m2r = 1'b0; m_err = 1'b1;
            end else begin
                m_rw = wb[0]; m_m2r = wb[1]; m_alu = alu; m_wd = wd;
            end
        end else begin
            x_addr = alu[31:2]; x_we = wr; x_wdata = wdata;
            waits = (lat < TO) ? lat : TO - 1;
            step(1'b1, 1'b0);
            nstall++;
            m_rw = 1'b0; m_m2r = 1'b0;
            check_regs();
            for (int k = 0; k < waits; k++) begin
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
                step(1'b1, 1'b1);
                nstall++;
                check_regs();
            end
            if (lat < TO) begin
                dmem_ack = 1'b1;
                dmem_rdata = fix ? fixv : $urandom;
                captured = dmem_rdata;
                step(1'b0, 1'b1);
                m_rw = wb[0]; m_m2r = wb[1] & ~(rd & wr); m_alu = alu; m_wd = wd;
                if (rd && !wr) m_rd = captured;
            end else begin
                dmem_ack = 1'b0;
                step(1'b0, 1'b1);
                m_rw = 1'b0; m_m2r = 1'b0; m_err = 1'b1;
            end
        end
        dmem_ack = 1'b0;
        check_regs();
        chk("dmem_req after", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        int ns;
        logic [31:0] a;
        int kind;
        clear_inputs();
        model_reset();
        apply_reset();

        // ALU op passes through in one cycle without stalling
        run_instr(1'b0, 1'b0, 32'h55, 32'h0, 2'b01, 5'd3, 0, 1'b0, 1'b0, '0, 1'b0, '0, ns);
        chk("alu RegWrite lit", 32'(RegWrite), 32'd1);
        chk("alu ALU_result_wb lit", ALU_result_wb, 32'h55);
        chk("alu stalls lit", 32'(ns), 32'd0);

        // branch decision is combinational
        Branch = 1'b1; Zero = 1'b1; Branch_dst = 30'h3F0; MemRead = 1'b0; MemWrite = 1'b0;
        WB = 2'b00; ALU_result = 32'h0; Write_Destination = 5'd0;
        #2;
        chk("branch PCSrc taken lit", 32'(PCSrc), 32'd1);
        chk("branch target lit", 32'(Branch_target), 32'h3F0);
        Zero = 1'b0;
        #2;
        chk("branch PCSrc not taken lit", 32'(PCSrc), 32'd0);
        step(1'b0, 1'b0);
        m_rw = 1'b0; m_m2r = 1'b0; m_alu = 32'h0; m_wd = 5'd0;
        check_regs();

        // load answered after three wait cycles
        run_instr(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 5'd5, 3, 1'b0, 1'b0, '0, 1'b1, 32'hDEADBEEF, ns);
        chk("load stalls lit", 32'(ns), 32'd4);
        chk("load addr lit", 32'(last_addr), 32'h40);
        chk("load ReadData lit", ReadData, 32'hDEADBEEF);
        chk("load RegWrite lit", 32'(RegWrite), 32'd1);
        chk("load MemtoReg lit", 32'(MemtoReg), 32'd1);
        chk("load dest lit", 32'(Write_Destination_wb), 32'd5);

        // store answered at once
        run_instr(1'b0, 1'b1, 32'h8, 32'h1234, 2'b00, 5'd0, 0, 1'b0, 1'b0, '0, 1'b0, '0, ns);
        chk("store stalls lit", 32'(ns), 32'd1);
        chk("store we lit", 32'(last_we), 32'd1);
        chk("store wdata lit", last_wdata, 32'h1234);
        chk("store addr lit", 32'(last_addr), 32'h2);
        chk("store RegWrite lit", 32'(RegWrite), 32'd0);
        chk("store keeps ReadData lit", ReadData, 32'hDEADBEEF);

        // misaligned load
        run_instr(1'b1, 1'b0, 32'h102, 32'h0, 2'b11, 5'd9, 0, 1'b0, 1'b0, '0, 1'b0, '0, ns);
        chk("misaligned stalls lit", 32'(ns), 32'd0);
        chk("misaligned mem_err lit", 32'(mem_err), 32'd1);
        chk("misaligned RegWrite lit", 32'(RegWrite), 32'd0);

        // no ack at all, so the access times out
        run_instr(1'b1, 1'b0, 32'h40, 32'h0, 2'b11, 5'd4, TO + 2, 1'b0, 1'b0, '0, 1'b0, '0, ns);
        chk("timeout stalls lit", 32'(ns), 32'd4);
        chk("timeout dmem_req lit", 32'(dmem_req), 32'd0);
        chk("timeout mem_err lit", 32'(mem_err), 32'd1);

        // reset asserted during the second access cycle takes effect without a clock edge
        MemRead = 1'b1; MemWrite = 1'b0; ALU_result = 32'h200; ReadData2 = 32'hCAFE;
        WB = 2'b11; Write_Destination = 5'd7; Branch = 1'b0; dmem_ack = 1'b0;
        x_addr = 30'h80; x_we = 1'b0; x_wdata = 32'hCAFE;
        step(1'b1, 1'b0);
        m_rw = 1'b0; m_m2r = 1'b0;
        step(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst dmem_addr", 32'(dmem_addr), 32'd0);
        chk("rst dmem_wdata", dmem_wdata, 32'd0);
        model_reset();
        check_regs();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs();
        // the first edge after reset must behave as IDLE
        run_instr(1'b1, 1'b0, 32'h200, 32'h0, 2'b11, 5'd7, 1, 1'b0, 1'b0, '0, 1'b0, '0, ns);
        chk("post-reset load stalls", 32'(ns), 32'd2);

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            if (n == 150) apply_reset();
            kind = $urandom_range(0, 9);
            a = $urandom;
            if (kind < 4) begin
                run_instr(1'b0, 1'b0, a, $urandom, 2'($urandom), 5'($urandom), 0,
                          1'($urandom), 1'($urandom), 30'($urandom), 1'b0, '0, ns);
            end else if (kind == 9) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                run_instr(1'($urandom), 1'b1, a, $urandom, 2'($urandom), 5'($urandom), 0,
                          1'($urandom), 1'($urandom), 30'($urandom), 1'b0, '0, ns);
            end else begin
                a[1:0] = 2'b00;
                run_instr(kind != 6, kind >= 6, a, $urandom, 2'($urandom), 5'($urandom),
                          $urandom_range(0, TO + 1), 1'($urandom), 1'($urandom), 30'($urandom),
                          1'b0, '0, ns);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles spent in ACCESS waiting for dmem_ack (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have these inputs from the EX/MEM register: Branch_dst [31:2] word target; Zero 1; ALU_result 32; ReadData2 32 store data; Write_Destination 5; WB 2, where WB[0]=RegWrite and WB[1]=MemtoReg; Branch 1; MemRead 1; MemWrite 1.
REQ-005 SHALL have these memory-side ports: dmem_req out 1; dmem_we out 1; dmem_addr out [31:2]; dmem_wdata out 32; dmem_rdata in 32; dmem_ack in 1.
REQ-006 SHALL have these outputs to fetch and hazard logic: PCSrc out 1; Branch_target out [31:2]; stall out 1; mem_err out 1 (sticky).
REQ-007 SHALL have these MEM/WB register outputs: RegWrite 1; MemtoReg 1; ReadData 32; ALU_result_wb 32; Write_Destination_wb 5.

Function
REQ-008 SHALL define mem_op = MemRead | MemWrite, misaligned = mem_op & (ALU_result[1:0] != 0), and valid_op = mem_op & ~misaligned.
REQ-009 SHALL implement an FSM with states IDLE and ACCESS.
REQ-010 IDLE with valid_op: stall=1 combinationally that cycle; next edge goes to ACCESS; registers dmem_req=1, dmem_addr=ALU_result[31:2], dmem_wdata=ReadData2, dmem_we=MemWrite.
REQ-011 If MemRead and MemWrite are both 1, SHALL perform a write (dmem_we=1) and treat MemtoReg as 0.
REQ-012 ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL hold stable until dmem_ack is sampled 1.
REQ-013 ACCESS with dmem_ack=1: stall=0 that cycle; at the edge, ReadData<=dmem_rdata (reads only; unchanged on writes), MEM/WB captures the instruction, dmem_req<=0, FSM goes to IDLE.
REQ-014 stall SHALL equal (IDLE & valid_op) | (ACCESS & ~dmem_ack & ~timeout_hit).
REQ-015 Timeout: an 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without ack; timeout_hit = (count == TIMEOUT-1) & ~dmem_ack.
REQ-016 On timeout_hit: stall=0; at the edge dmem_req<=0, mem_err<=1, a bubble is written to MEM/WB, FSM goes to IDLE.
REQ-017 Misaligned access in IDLE: no request, no stall; at the edge mem_err<=1 and a bubble is written to MEM/WB.
REQ-018 Non-memory instruction in IDLE: MEM/WB SHALL capture WB, ALU_result and Write_Destination at the next edge (1-cycle latency); ReadData unchanged.
REQ-019 Every cycle with stall=1 SHALL write a bubble into MEM/WB: RegWrite=0, MemtoReg=0, other fields unchanged.
REQ-020 PCSrc SHALL equal Branch & Zero & ~stall combinationally, and Branch_target SHALL equal Branch_dst.
REQ-021 mem_err, once set, SHALL remain 1 until reset.
REQ-022 ACK arriving while IDLE SHALL be ignored.

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, wait counter, mem_err, RegWrite, MemtoReg, ReadData, ALU_result_wb and Write_Destination_wb all 0.
REQ-024 Reset asserted during ACCESS SHALL abandon the access with dmem_req=0 immediately; no MEM/WB update occurs.
REQ-025 After rst_n deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-026 Load: MemRead=1, ALU_result=0x100, WB=2'b11, Write_Destination=5, ack after 3 ACCESS cycles with rdata=0xDEADBEEF -> stall high for 4 cycles, dmem_addr=0x40, then RegWrite=1, MemtoReg=1, ReadData=0xDEADBEEF, Write_Destination_wb=5.
REQ-027 Store: MemWrite=1, ALU_result=0x8, ReadData2=0x1234, immediate ack -> dmem_we=1, dmem_wdata=0x1234, dmem_addr=0x2, one stall cycle, RegWrite=0.
REQ-028 ALU op: WB=2'b01, ALU_result=0x55 -> next edge RegWrite=1, ALU_result_wb=0x55, stall never 1.
REQ-029 Misaligned load: ALU_result=0x102 -> no dmem_req, mem_err=1, RegWrite=0; error and timeout cases: with TIMEOUT=4 and no ack -> 4 stall cycles, then dmem_req=0 and mem_err=1.
REQ-030 Branch: Branch=1, Zero=1, Branch_dst=0x3F0 -> PCSrc=1, Branch_target=0x3F0 in the same cycle; with Zero=0 -> PCSrc=0.
REQ-031 Reset mid-access: rst_n low in the 2nd ACCESS cycle -> dmem_req=0 and all outputs 0 without waiting for a clock edge.
